// File: rtl/silife_grid8_if.sv
// Signal bundle for silife_grid8: row write port, generation request,
// display read port and status outputs.
interface silife_grid8_if;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data;
  logic        step;
  logic        wrap;
  logic [2:0]  row_select;
  logic [7:0]  cells;
  logic        busy;
  logic [15:0] generation;

  modport master (
    output wr_en, wr_row, wr_data, step, wrap, row_select,
    input  cells, busy, generation
  );

  modport slave (
    input  wr_en, wr_row, wr_data, step, wrap, row_select,
    output cells, busy, generation
  );
endinterface

// File: rtl/silife_grid8.sv
// 8x8 Game of Life engine: computes one row per cycle into a work buffer,
// then commits the whole grid at once so the display never sees a partial generation.
module silife_grid8 (
  input  logic          clk,
  input  logic          reset,
  silife_grid8_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t      state;
  logic [7:0]  cur [8];
  logic [7:0]  nxt [8];
  logic [2:0]  row_cnt;
  logic        wrap_q;
  logic        busy_q;
  logic [15:0] gen_q;
  logic [7:0]  row_above;
  logic [7:0]  row_below;
  logic [7:0]  row_new;

  function automatic logic [7:0] life_row(
    input logic [7:0] up,
    input logic [7:0] mid,
    input logic [7:0] dn,
    input logic       wrap_en
  );
    logic [7:0] res;
    logic [2:0] cl;
    logic [2:0] cr;
    logic       keep_l;
    logic       keep_r;
    logic [3:0] n;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      cl     = 3'(c + 7);
      cr     = 3'(c + 1);
      keep_l = wrap_en || (c != 0);
      keep_r = wrap_en || (c != 7);
      // 4-bit count so a fully surrounded cell reads 8, not 0
      n = {3'b000, up[c]} + {3'b000, dn[c]}
        + {3'b000, keep_l & up[cl]}  + {3'b000, keep_r & up[cr]}
        + {3'b000, keep_l & mid[cl]} + {3'b000, keep_r & mid[cr]}
        + {3'b000, keep_l & dn[cl]}  + {3'b000, keep_r & dn[cr]};
      res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
    end
    return res;
  endfunction

  always_comb begin
    row_above = (!wrap_q && (row_cnt == 3'd0)) ? 8'h00 : cur[row_cnt - 3'd1];
    row_below = (!wrap_q && (row_cnt == 3'd7)) ? 8'h00 : cur[row_cnt + 3'd1];
    row_new   = life_row(row_above, cur[row_cnt], row_below, wrap_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= 3'd0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      gen_q   <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        cur[i] <= 8'h00;
        nxt[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          // a write in the same cycle as a step wins; the step is dropped
          if (bus.wr_en) begin
            cur[bus.wr_row] <= bus.wr_data;
          end else if (bus.step) begin
            state   <= COMPUTE;
            row_cnt <= 3'd0;
            wrap_q  <= bus.wrap;
            busy_q  <= 1'b1;
          end
        end
        COMPUTE: begin
          nxt[row_cnt] <= row_new;
          row_cnt      <= row_cnt + 3'd1;
          if (row_cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 8; i++) cur[i] <= nxt[i];
          gen_q  <= gen_q + 16'd1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cells      = cur[bus.row_select];
  assign bus.busy       = busy_q;
  assign bus.generation = gen_q;

endmodule

// File: tb/tb_silife_grid8.sv
// Scoreboard bench for silife_grid8: an independent Life model predicts each
// generation, results are queued at step time and checked when busy drops.
module tb_silife_grid8;

  typedef logic [7:0][7:0] grid_t;
  typedef struct {
    grid_t       grid;
    logic [15:0] gen;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  silife_grid8_if bus_if ();

  silife_grid8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  exp_t        sb_q[$];
  grid_t       model;
  logic [15:0] model_gen;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model written cell-by-cell with explicit coordinates
  function automatic grid_t lifeModel(input grid_t g, input logic wrap_v);
    grid_t res;
    int    n;
    int    rr;
    int    cc;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap_v) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) n += int'(g[rr][cc]);
          end
        end
        res[r][c] = (n == 3) || (g[r][c] && n == 2);
      end
    end
    return res;
  endfunction

  task automatic checkGrid(input string tag, input grid_t exp_g);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus_if.row_select = 3'(r);
      #1;
      checkOutput($sformatf("%s_row%0d", tag, r), 32'(bus_if.cells), 32'(exp_g[r]));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.step  = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model     = '0;
    model_gen = 16'd0;
    sb_q.delete();
  endtask

  task automatic checkCleared(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    checkOutput({tag, "_gen"}, 32'(bus_if.generation), 32'd0);
    checkGrid(tag, '0);
  endtask

  task automatic writeRow(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_row  = r;
    bus_if.wr_data = d;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
    model[r]     = d;
  endtask

  // Issue one step; optionally hammer wr_en/step while busy. wrap is flipped
  // right after acceptance so a late wrap change would corrupt the result.
  task automatic applyStimulus(input logic wrap_v, input bit lockout);
    exp_t  e;
    exp_t  got;
    grid_t old_g;
    int    cyc;
    old_g  = model;
    e.grid = lifeModel(model, wrap_v);
    e.gen  = model_gen + 16'd1;
    @(negedge clk);
    bus_if.wrap = wrap_v;
    bus_if.step = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus_if.step       = 1'b0;
    bus_if.wrap       = ~wrap_v;
    bus_if.row_select = 3'd0;
    cyc = 0;
    @(negedge clk);
    while (bus_if.busy === 1'b1 && cyc < 20) begin
      cyc++;
      checkOutput("busy_display", 32'(bus_if.cells), 32'(old_g[bus_if.row_select]));
      if (lockout && cyc == 2) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_row  = 3'd0;
        bus_if.wr_data = 8'hFF;
        bus_if.step    = 1'b1;
      end
      @(posedge clk);
      #1;
      bus_if.wr_en      = 1'b0;
      bus_if.step       = 1'b0;
      bus_if.row_select = bus_if.row_select + 3'd1;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(cyc), 32'd9);
    got = sb_q.pop_front();
    checkOutput("first_idle_display", 32'(bus_if.cells), 32'(got.grid[bus_if.row_select]));
    checkOutput("generation", 32'(bus_if.generation), 32'(got.gen));
    checkGrid("grid", got.grid);
    model     = got.grid;
    model_gen = got.gen;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    grid_t g;
    logic  w;
    reset             = 1'b1;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_row     = 3'd0;
    bus_if.wr_data    = 8'h00;
    bus_if.step       = 1'b0;
    bus_if.wrap       = 1'b0;
    bus_if.row_select = 3'd0;
    repeat (2) @(posedge clk);
    doReset();
    checkCleared("reset");

    $display("[TB] blinker");
    writeRow(3'd3, 8'h1C);
    @(negedge clk);
    bus_if.row_select = 3'd3;
    #1;
    checkOutput("write_visible", 32'(bus_if.cells), 32'h1C);
    applyStimulus(1'b0, 1'b0);
    g = '0;
    g[2] = 8'h08; g[3] = 8'h08; g[4] = 8'h08;
    checkGrid("blinker1", g);
    applyStimulus(1'b0, 1'b0);
    g = '0;
    g[3] = 8'h1C;
    checkGrid("blinker2", g);
    checkOutput("blinker_gen", 32'(bus_if.generation), 32'd2);

    $display("[TB] still life");
    doReset();
    writeRow(3'd0, 8'h03);
    writeRow(3'd1, 8'h03);
    repeat (3) applyStimulus(1'b0, 1'b0);
    g = '0;
    g[0] = 8'h03; g[1] = 8'h03;
    checkGrid("block", g);
    checkOutput("block_gen", 32'(bus_if.generation), 32'd3);

    $display("[TB] edge wrap");
    doReset();
    writeRow(3'd0, 8'h83);
    applyStimulus(1'b1, 1'b0);
    g = '0;
    g[7] = 8'h01; g[0] = 8'h01; g[1] = 8'h01;
    checkGrid("wrap_on", g);
    doReset();
    writeRow(3'd0, 8'h83);
    applyStimulus(1'b0, 1'b0);
    checkGrid("wrap_off", '0);

    $display("[TB] busy lockout");
    doReset();
    writeRow(3'd3, 8'h1C);
    applyStimulus(1'b0, 1'b1);
    g = '0;
    g[2] = 8'h08; g[3] = 8'h08; g[4] = 8'h08;
    checkGrid("lockout", g);
    checkOutput("lockout_gen", 32'(bus_if.generation), 32'd1);

    $display("[TB] write and step together");
    @(negedge clk);
    bus_if.wr_en   = 1'b1;
    bus_if.step    = 1'b1;
    bus_if.wr_row  = 3'd6;
    bus_if.wr_data = 8'h5A;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
    bus_if.step  = 1'b0;
    model[6]     = 8'h5A;
    @(negedge clk);
    checkOutput("both_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("both_gen", 32'(bus_if.generation), 32'd1);
    checkGrid("both", model);

    $display("[TB] reset mid-step");
    doReset();
    writeRow(3'd3, 8'h1C);
    @(negedge clk);
    bus_if.wrap = 1'b0;
    bus_if.step = 1'b1;
    @(posedge clk);
    #1;
    bus_if.step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model     = '0;
    model_gen = 16'd0;
    checkCleared("abort");
    applyStimulus(1'b0, 1'b0);
    checkGrid("after_abort", '0);
    checkOutput("after_abort_gen", 32'(bus_if.generation), 32'd1);

    $display("[TB] random grids");
    for (int k = 0; k < 4; k++) begin
      doReset();
      for (int r = 0; r < 8; r++) writeRow(3'(r), 8'($urandom_range(0, 255)));
      w = 1'($urandom_range(0, 1));
      applyStimulus(w, 1'b0);
      applyStimulus(~w, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
